// File: rtl/seq_divider.sv
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor, 2N iterations then a sign-fixup cycle.
// Build option SEQ_DIV_SAT_EN: saturate the quotient on overflow instead of wrapping it.
module seq_divider #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           dz
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0]  LAST_ITER = CW'(2*N-1);
  localparam logic [2*N-1:0] POS_LIM   = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] NEG_LIM   = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   Q_MAX     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   Q_MIN     = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t         state_r;
  state_t         state_s;

  logic [2*N-1:0] dq_r;
  logic [N:0]     pr_r;
  logic [N-1:0]   mb_r;
  logic [CW-1:0]  cnt_r;
  logic           sign_a_r;
  logic           sign_q_r;
  logic           bz_r;

  logic [2*N-1:0] abs_a_s;
  logic [N-1:0]   abs_b_s;
  logic [N+1:0]   pr_sh_s;
  logic [N+1:0]   trial_s;
  logic [2*N-1:0] dq_s;
  logic [N:0]     pr_s;

  logic [N-1:0]   q_wrap_s;
  logic [N-1:0]   q_s;
  logic [N-1:0]   r_s;
  logic           ovf_s;
  logic           dz_s;
  logic           busy_s;
  logic           done_s;

  logic [N-1:0]   quotient_r;
  logic [N-1:0]   remainder_r;
  logic           busy_r;
  logic           done_r;
  logic           ovf_r;
  logic           dz_r;

  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign ovf       = ovf_r;
  assign dz        = dz_r;

  // Operand magnitudes taken in the load cycle; the most negative values map to 2^(W-1) unsigned.
  always_comb begin
    abs_a_s = a;
    abs_b_s = b;
    if (a[2*N-1]) begin
      abs_a_s = -a;
    end else begin
      abs_a_s = a;
    end
    if (b[N-1]) begin
      abs_b_s = -b;
    end else begin
      abs_b_s = b;
    end
  end

  // One restoring step: shift {remainder, dividend} left, trial-subtract |b|, keep or restore.
  always_comb begin
    pr_sh_s = {pr_r, dq_r[2*N-1]};
    trial_s = pr_sh_s - {2'b00, mb_r};
    dq_s    = {dq_r[2*N-2:0], 1'b0};
    pr_s    = pr_sh_s[N:0];
    if (trial_s[N+1]) begin
      dq_s = {dq_r[2*N-2:0], 1'b0};
      pr_s = pr_sh_s[N:0];
    end else begin
      dq_s = {dq_r[2*N-2:0], 1'b1};
      pr_s = trial_s[N:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_ITER) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Iteration datapath: operand latch in IDLE, one shift/subtract per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq_r     <= {(2*N){1'b0}};
      pr_r     <= {(N+1){1'b0}};
      mb_r     <= {N{1'b0}};
      cnt_r    <= {CW{1'b0}};
      sign_a_r <= 1'b0;
      sign_q_r <= 1'b0;
      bz_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            dq_r     <= abs_a_s;
            pr_r     <= {(N+1){1'b0}};
            mb_r     <= abs_b_s;
            cnt_r    <= {CW{1'b0}};
            sign_a_r <= a[2*N-1];
            sign_q_r <= a[2*N-1] ^ b[N-1];
            bz_r     <= (b == {N{1'b0}});
          end
        end
        CALC: begin
          dq_r  <= dq_s;
          pr_r  <= pr_s;
          cnt_r <= cnt_r + CW'(1);
        end
        default: begin
          dq_r <= dq_r;
        end
      endcase
    end
  end

  // Sign fixup, overflow detection and next values of the output registers.
  always_comb begin
    busy_s   = (state_s != IDLE);
    done_s   = (state_r == FIX);
    q_wrap_s = dq_r[N-1:0];
    q_s      = {N{1'b0}};
    r_s      = {N{1'b0}};
    ovf_s    = 1'b0;
    dz_s     = 1'b0;
    if (sign_q_r) begin
      q_wrap_s = -dq_r[N-1:0];
      ovf_s    = (dq_r > NEG_LIM);
    end else begin
      q_wrap_s = dq_r[N-1:0];
      ovf_s    = (dq_r > POS_LIM);
    end
    // The remainder magnitude is below |b| <= 2^(N-1), so it always fits in N bits.
    if (sign_a_r) begin
      r_s = -pr_r[N-1:0];
    end else begin
      r_s = pr_r[N-1:0];
    end
`ifdef SEQ_DIV_SAT_EN
    if (ovf_s) begin
      q_s = sign_q_r ? Q_MIN : Q_MAX;
    end else begin
      q_s = q_wrap_s;
    end
`else
    if (ovf_s) begin
      q_s = q_wrap_s;
    end else begin
      q_s = q_wrap_s;
    end
`endif
    if (bz_r) begin
      q_s   = {N{1'b0}};
      r_s   = {N{1'b0}};
      ovf_s = 1'b0;
      dz_s  = 1'b1;
    end else begin
      dz_s  = 1'b0;
    end
  end

  // Output registers: results and flags load only in FIX, busy/done track the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient_r  <= {N{1'b0}};
      remainder_r <= {N{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
      dz_r        <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      if (state_r == FIX) begin
        quotient_r  <= q_s;
        remainder_r <= r_s;
        ovf_r       <= ovf_s;
        dz_r        <= dz_s;
      end
    end
  end

endmodule
